// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder constants: opcodes, descriptor class codes, FSM states
// and the signed range helper used by the legality checks.
package instr_encoder_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {
        CLS_LOAD  = 3'd0,
        CLS_STORE = 3'd1,
        CLS_RTYPE = 3'd2,
        CLS_ITYPE = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_JAL   = 3'd5
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } enc_state_e;

    // Immediates are two's-complement, so compare them as signed values.
    function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_packer.sv
// Combinational descriptor-to-machine-word packer; also reports whether the
// descriptor fits the chosen format.
module instr_encoder_packer
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  cls_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    logic       is_shift;
    logic [6:0] funct7;

    assign is_shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);
    assign funct7   = {1'b0, funct7b5_i, 5'b00000};

    always_comb begin
        word_o  = '0;
        legal_o = 1'b0;
        case (cls_i)
            CLS_LOAD: begin
                word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
                legal_o = imm_in_range(imm_i, -2048, 2047);
            end
            CLS_STORE: begin
                word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
                legal_o = imm_in_range(imm_i, -2048, 2047);
            end
            CLS_RTYPE: begin
                word_o  = {funct7, rs2_i, rs1_i, funct3_i, rd_i, OP_RTYPE};
                legal_o = 1'b1;
            end
            CLS_ITYPE: begin
                // Shifts reuse the funct7 slot and carry a 5-bit shift amount.
                if (is_shift) begin
                    word_o  = {funct7, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_ITYPE};
                    legal_o = imm_in_range(imm_i, 0, 31);
                end else begin
                    word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ITYPE};
                    legal_o = imm_in_range(imm_i, -2048, 2047);
                end
            end
            CLS_BEQ: begin
                word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], OP_BEQ};
                legal_o = imm_in_range(imm_i, -4096, 4094) && !imm_i[0];
            end
            CLS_JAL: begin
                word_o  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
                legal_o = imm_in_range(imm_i, -1048576, 1048574) && !imm_i[0];
            end
            default: begin
                word_o  = '0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: accepts field-level descriptors, packs them and
// writes one word every two cycles to consecutive addresses from BASE_ADDR.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 64,
    localparam int         CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_class,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7b5,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [31:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [31:0]   imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [CW-1:0] count,
    output logic          err,
    output logic          done,
    output logic [1:0]    dbg_state
);

    // Handshake: a descriptor transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready is registered and never depends on in_valid.

    enc_state_e    state_q;
    logic          in_ready_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [31:0]   addr_d;
    logic          err_q;
    logic          done_q;
    logic          last_q;

    logic [31:0]   pk_word;
    logic          pk_legal;

    instr_encoder_packer u_packer (
        .cls_i      (in_class),
        .funct3_i   (in_funct3),
        .funct7b5_i (in_funct7b5),
        .rd_i       (in_rd),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .imm_i      (in_imm),
        .word_o     (pk_word),
        .legal_o    (pk_legal)
    );

    assign count_d = count_q + CW'(1);
    assign addr_d  = BASE_ADDR + (32'(count_q) << 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else if (clear) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        last_q <= in_last;
                        if (pk_legal) begin
                            state_q    <= ST_WRITE;
                            in_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            addr_q     <= addr_d;
                            wdata_q    <= pk_word;
                        end else begin
                            // Rejected descriptors consume no slot but may still end the session.
                            err_q <= 1'b1;
                            if (in_last) begin
                                state_q    <= ST_DONE;
                                in_ready_q <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    we_q    <= 1'b0;
                    count_q <= count_d;
                    if (last_q || (count_d == CW'(DEPTH))) begin
                        state_q    <= ST_DONE;
                        in_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b1;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // A restart or reset during the write cycle must keep the pending word out of memory.
    assign imem_we    = we_q & ~clear & ~reset;
    assign in_ready   = in_ready_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;
    assign done       = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: scoreboarded writes on a DEPTH=64 instance and a
// DEPTH=4 instance at a non-zero base address.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_valid4;
    logic [2:0]  in_class;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, imem_we, err, done;
    logic [31:0] imem_addr, imem_wdata;
    logic [6:0]  count;
    logic [1:0]  dbg_state;

    logic        in_ready4, imem_we4, err4, done4;
    logic [31:0] imem_addr4, imem_wdata4;
    logic [2:0]  count4;
    logic [1:0]  dbg_state4;

    logic [63:0] exp_q[$];
    logic [63:0] exp4_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(64)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .err(err), .done(done), .dbg_state(dbg_state)
    );

    instr_encoder #(.BASE_ADDR(32'h0000_0100), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_class(in_class), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .count(count4), .err(err4), .done(done4), .dbg_state(dbg_state4)
    );

    // Advance to the next falling edge and score any memory write seen there.
    task automatic cyc();
        logic [63:0] e;
        @(negedge clk);
        if (imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
        if (imem_we4 === 1'b1) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write4: addr=%h data=%h required no write", imem_addr4, imem_wdata4);
            end else begin
                e = exp4_q.pop_front();
                if ({imem_addr4, imem_wdata4} !== e) begin
                    errors++;
                    $display("FAIL write4: addr=%h data=%h required addr=%h data=%h",
                             imem_addr4, imem_wdata4, e[63:32], e[31:0]);
                end
            end
        end
    endtask

    // Drive one descriptor on the main instance; returns just after the accepting edge.
    task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        int n = 0;
        cyc();
        while (in_ready !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        in_class = cls; in_funct3 = f3; in_funct7b5 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_clear();
        cyc();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", imem_we); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", imem_wdata); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++; if (err !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_err_done: got %b%b required 00", err, done); end
        checks++; if (imem_addr4 !== 32'h100) begin errors++; $display("FAIL reset_addr4: got %h required 100", imem_addr4); end
        reset = 1'b0;
        repeat (2) cyc();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", in_ready); end
    endtask

    task automatic test_basic();
        exp_q.push_back({32'h0000_0000, 32'h0020_81B3});
        send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_write: got %b required 0", in_ready); end
        repeat (2) cyc();
        checks++; if (count !== 7'd1) begin errors++; $display("FAIL count_after_rtype: got %0d required 1", count); end
        exp_q.push_back({32'h0000_0004, 32'h0051_2423});
        send(3'd1, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 32'd8, 1'b0);
        exp_q.push_back({32'h0000_0008, 32'hFE20_8CE3});
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0);
        repeat (2) cyc();
        checks++; if (count !== 7'd3) begin errors++; $display("FAIL count_after_beq: got %0d required 3", count); end
    endtask

    task automatic test_illegal();
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0);
        cyc();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_beq_odd: got %b required 1", err); end
        checks++; if (count !== 7'd3) begin errors++; $display("FAIL count_beq_odd: got %0d required 3", count); end
        send(3'd3, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd4096, 1'b0);
        send(3'd6, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0, 1'b0);
        send(3'd3, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0);
        send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
        cyc();
        checks++; if (count !== 7'd3) begin errors++; $display("FAIL count_after_illegal: got %0d required 3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_illegal: got %b required 1", in_ready); end
        exp_q.push_back({32'h0000_000C, 32'hFFF0_0293});
        send(3'd3, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, -32'sd1, 1'b0);
        repeat (2) cyc();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", err); end
    endtask

    task automatic test_formats();
        exp_q.push_back({32'h0000_0010, 32'hFFC1_2303});
        send(3'd0, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, -32'sd4, 1'b0);
        exp_q.push_back({32'h0000_0014, 32'h4034_5393});
        send(3'd3, 3'd5, 1'b1, 5'd7, 5'd8, 5'd0, 32'd3, 1'b0);
        exp_q.push_back({32'h0000_0018, 32'h4020_81B3});
        send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        exp_q.push_back({32'h0000_001C, 32'h7E20_8FE3});
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b0);
        exp_q.push_back({32'h0000_0020, 32'h7FF0_0293});
        send(3'd3, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2047, 1'b0);
        repeat (2) cyc();
        checks++; if (count !== 7'd9) begin errors++; $display("FAIL count_after_formats: got %0d required 9", count); end
    endtask

    task automatic test_last();
        exp_q.push_back({32'h0000_0024, 32'h0010_00EF});
        send(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
        cyc();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early: got %b required 0", done); end
        cyc();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_after_last: got %b required 1", done); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_in_done: got %b required 0", in_ready); end
        checks++; if (count !== 7'd10) begin errors++; $display("FAIL count_final: got %0d required 10", count); end
        in_class = 3'd2;
        in_valid = 1'b1;
        repeat (5) cyc();
        in_valid = 1'b0;
        checks++; if (done !== 1'b1 || count !== 7'd10) begin errors++; $display("FAIL done_hold: got done=%b count=%0d required 1 10", done, count); end
    endtask

    task automatic test_clear_write();
        pulse_clear();
        cyc();
        checks++; if (done !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL clear_from_done: got done=%b ready=%b required 0 1", done, in_ready); end
        send(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0);
        send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        clear = 1'b1;
        cyc();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL clear_drops_we: got %b required 0", imem_we); end
        @(posedge clk);
        #1;
        clear = 1'b0;
        cyc();
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL clear_count: got %0d required 0", count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b required 0", err); end
        checks++; if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin errors++; $display("FAIL clear_idle: got ready=%b state=%0d required 1 0", in_ready, dbg_state); end
    endtask

    task automatic test_reset_mid();
        exp_q.push_back({32'h0000_0000, 32'h0020_81B3});
        send(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        send(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        send(3'd0, 3'd2, 1'b0, 5'd6, 5'd2, 5'd0, 32'd4, 1'b0);
        reset = 1'b1;
        cyc();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_drops_we: got %b required 0", imem_we); end
        @(posedge clk);
        #1;
        cyc();
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_mid_addr: got %h required 0", imem_addr); end
        checks++; if (count !== 7'd0 || err !== 1'b0) begin errors++; $display("FAIL reset_mid_count_err: got %0d %b required 0 0", count, err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %b required 0", in_ready); end
        reset = 1'b0;
        exp_q.push_back({32'h0000_0000, 32'h4020_81B3});
        send(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        repeat (2) cyc();
        checks++; if (count !== 7'd1) begin errors++; $display("FAIL count_after_reset: got %0d required 1", count); end
    endtask

    task automatic test_depth();
        in_class = 3'd3; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
        in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd1; in_last = 1'b0;
        for (int i = 0; i < 4; i++)
            exp4_q.push_back({32'h0000_0100 + 32'(4 * i), 32'h0010_0093});
        in_valid4 = 1'b1;
        repeat (20) cyc();
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL depth_done: got %b required 1", done4); end
        checks++; if (count4 !== 3'd4) begin errors++; $display("FAIL depth_count: got %0d required 4", count4); end
        checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL depth_ready: got %b required 0", in_ready4); end
        checks++; if (exp4_q.size() != 0) begin errors++; $display("FAIL depth_writes: got %0d pending required 0", exp4_q.size()); end
        in_valid4 = 1'b0;
    endtask

    initial begin
        clear = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0;
        in_class = 3'd0; in_funct3 = 3'd0; in_funct7b5 = 1'b0;
        in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0; in_last = 1'b0;
        test_reset();
        test_basic();
        test_illegal();
        test_formats();
        test_last();
        test_clear_write();
        test_reset_mid();
        test_depth();
        repeat (2) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_writes: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
